bcd_calendar_clock: RTL

- Parametrised successor of the team's BCD digital clock.
- Adds a month field with per-month day lengths, a configurable prescaler with a fast-test divider, 12/24-hour display and an hour/minute alarm.
- Sits between the 1 kHz board clock and the display/FND driver. Every time field is packed BCD.

---
 rtl/bcd_clock_pkg.sv | 76 +++++++
 rtl/bcd_clock_field_cntr.sv | 62 ++++++
 rtl/bcd_calendar_clock.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bcd_clock_pkg.sv
// -----------------------------------------------------------------------------
// bcd_clock_pkg
// Shared constants and helpers for the BCD calendar clock.
//   - Field min/max limits (packed BCD)
//   - bcd_inc   : packed-BCD increment of a two-digit value
//   - dim       : days in a month (BCD) for a BCD month number
//   - bcd_valid : range/nibble check used when loading set values
//   - to_12h    : internal 24-hour BCD hour -> {pm, 12-hour BCD hour}
// -----------------------------------------------------------------------------
package bcd_clock_pkg;

    localparam logic [7:0] SEC_MIN  = 8'h00;
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MIN  = 8'h00;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MIN = 8'h00;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] DAY_MIN  = 8'h01;
    localparam logic [7:0] MON_MIN  = 8'h01;
    localparam logic [7:0] MON_MAX  = 8'h12;

    // Two-digit packed-BCD increment; the caller handles the field wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Days in month; unknown month codes fall back to 31.
    function automatic logic [7:0] dim(input logic [7:0] mon, input logic [7:0] feb_days);
        logic [7:0] r;
        case (mon)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: r = 8'h31;
            8'h04, 8'h06, 8'h09, 8'h11:                      r = 8'h30;
            8'h02:                                           r = feb_days;
            default:                                         r = 8'h31;
        endcase
        return r;
    endfunction

    // Both nibbles must be decimal digits and the value must lie in [mn, mx].
    function automatic logic bcd_valid(input logic [7:0] value,
                                       input logic [7:0] mn,
                                       input logic [7:0] mx);
        return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) &&
               (value >= mn) && (value <= mx);
    endfunction

    // Returns {pm, hour12}. 00 shows as 12 AM, 12 as 12 PM, 13-23 as 01-11 PM.
    function automatic logic [8:0] to_12h(input logic [7:0] hour);
        logic [7:0] bin;
        logic [7:0] h12;
        logic [7:0] tens_rem;
        logic [8:0] r;
        bin      = ({4'd0, hour[7:4]} * 8'd10) + {4'd0, hour[3:0]};
        h12      = bin - 8'd12;
        tens_rem = h12 - 8'd10;
        if (bin == 8'd0) begin
            r = {1'b0, 8'h12};
        end else if (bin < 8'd12) begin
            r = {1'b0, hour};
        end else if (bin == 8'd12) begin
            r = {1'b1, 8'h12};
        end else if (h12 >= 8'd10) begin
            r = {1'b1, 4'h1, tens_rem[3:0]};
        end else begin
            r = {1'b1, 4'h0, h12[3:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_clock_field_cntr.sv
// -----------------------------------------------------------------------------
// bcd_field_cntr
// One packed-BCD time/date field with a dynamic upper bound.
//   clk_i      : clock
//   rstn_i     : synchronous active-low reset, field returns to MIN
//   max_i      : current field maximum (BCD), may change at run time
//   en_i       : advance by one this cycle
//   load_i     : load load_val_i (has priority over en_i)
//   load_val_i : already-validated load value
//   bcd_o      : field value
//   carry_o    : combinational, high when this advance wraps the field
// -----------------------------------------------------------------------------
module bcd_field_cntr
    import bcd_clock_pkg::*;
#(
    parameter logic [7:0] MIN = 8'h00
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] max_i,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [7:0] bcd_o,
    output logic       carry_o
);

    logic [7:0] bcd_q;
    logic [7:0] bcd_d;
    logic       at_max_s;

    // ">=" rather than "==" so a value left above a shrunken maximum still wraps.
    assign at_max_s = (bcd_q >= max_i);
    assign carry_o  = en_i & ~load_i & at_max_s;
    assign bcd_o    = bcd_q;

    // Next-state: load beats advance; advance wraps to MIN at the maximum.
    always_comb begin
        bcd_d = bcd_q;
        if (load_i) begin
            bcd_d = load_val_i;
        end else if (en_i) begin
            if (at_max_s) begin
                bcd_d = MIN;
            end else begin
                bcd_d = bcd_inc(bcd_q);
            end
        end else begin
            bcd_d = bcd_q;
        end
    end

    // Field register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            bcd_q <= MIN;
        end else begin
            bcd_q <= bcd_d;
        end
    end

endmodule

// File: rtl/bcd_calendar_clock.sv
// -----------------------------------------------------------------------------
// bcd_calendar_clock
// Packed-BCD time-of-day and date counter with prescaler, set mode,
// 12/24-hour display and an hour/minute alarm.
//   CLK1K          : 1 kHz system clock
//   RSTN           : synchronous active-low reset
//   SET_EN         : load fields from *_SET, counting frozen
//   FAST           : use FAST_DIV instead of DIV as the second length
//   MODE12         : HOUR output in 12-hour format
//   SEC/MIN/HOUR/DAY/MON_SET : BCD load values (HOUR_SET is 24-hour)
//   ALM_EN, ALM_MIN, ALM_HOUR : alarm enable and 24-hour alarm time
//   SEC/MIN/HOUR/DAY/MON     : BCD outputs (HOUR formatted per MODE12)
//   PM             : internal hour >= 12
//   TICK           : one-cycle pulse on each one-second advance
//   ALARM          : one-cycle pulse on the tick that reaches hh:mm:00
// -----------------------------------------------------------------------------
module bcd_calendar_clock
    import bcd_clock_pkg::*;
#(
    parameter int         DIV      = 1000,
    parameter int         FAST_DIV = 10,
    parameter int         CNT_W    = 10,
    parameter logic [7:0] FEB_DAYS = 8'h28
) (
    input  logic       CLK1K,
    input  logic       RSTN,
    input  logic       SET_EN,
    input  logic       FAST,
    input  logic       MODE12,
    input  logic [7:0] SEC_SET,
    input  logic [7:0] MIN_SET,
    input  logic [7:0] HOUR_SET,
    input  logic [7:0] DAY_SET,
    input  logic [7:0] MON_SET,
    input  logic       ALM_EN,
    input  logic [7:0] ALM_MIN,
    input  logic [7:0] ALM_HOUR,
    output logic [7:0] SEC,
    output logic [7:0] MIN,
    output logic [7:0] HOUR,
    output logic [7:0] DAY,
    output logic [7:0] MON,
    output logic       PM,
    output logic       TICK,
    output logic       ALARM
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] lim_m1_s;
    logic             tick_q;
    logic             tick_d;
    logic             alarm_q;
    logic             alarm_d;

    logic [7:0] sec_s, min_s, hour_s, day_s, mon_s;
    logic       sec_c_s, min_c_s, hour_c_s, day_c_s;
    logic [7:0] sec_ld_s, min_ld_s, hour_ld_s, day_ld_s, mon_ld_s;
    logic [7:0] day_max_s;
    logic [7:0] min_nxt_s, hour_nxt_s;
    logic [8:0] h12_s;

    assign lim_m1_s = FAST ? CNT_W'(FAST_DIV - 1) : CNT_W'(DIV - 1);

    // Prescaler: ">=" so a count left above the new limit after a FAST
    // switch still produces a tick on the next edge instead of running on.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (SET_EN) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (cnt_q >= lim_m1_s) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            tick_d = 1'b0;
        end
    end

    // Validated load values; DAY is checked against the month being loaded.
    assign sec_ld_s  = bcd_valid(SEC_SET,  SEC_MIN,  SEC_MAX)  ? SEC_SET  : SEC_MIN;
    assign min_ld_s  = bcd_valid(MIN_SET,  MIN_MIN,  MIN_MAX)  ? MIN_SET  : MIN_MIN;
    assign hour_ld_s = bcd_valid(HOUR_SET, HOUR_MIN, HOUR_MAX) ? HOUR_SET : HOUR_MIN;
    assign mon_ld_s  = bcd_valid(MON_SET,  MON_MIN,  MON_MAX)  ? MON_SET  : MON_MIN;
    assign day_ld_s  = bcd_valid(DAY_SET,  DAY_MIN,  dim(mon_ld_s, FEB_DAYS)) ? DAY_SET : DAY_MIN;

    assign day_max_s = dim(mon_s, FEB_DAYS);

    // The fields advance on tick_d, i.e. the same edge that registers TICK.
    bcd_field_cntr #(.MIN(SEC_MIN)) u_sec (
        .clk_i(CLK1K), .rstn_i(RSTN), .max_i(SEC_MAX), .en_i(tick_d),
        .load_i(SET_EN), .load_val_i(sec_ld_s), .bcd_o(sec_s), .carry_o(sec_c_s)
    );
    bcd_field_cntr #(.MIN(MIN_MIN)) u_min (
        .clk_i(CLK1K), .rstn_i(RSTN), .max_i(MIN_MAX), .en_i(sec_c_s),
        .load_i(SET_EN), .load_val_i(min_ld_s), .bcd_o(min_s), .carry_o(min_c_s)
    );
    bcd_field_cntr #(.MIN(HOUR_MIN)) u_hour (
        .clk_i(CLK1K), .rstn_i(RSTN), .max_i(HOUR_MAX), .en_i(min_c_s),
        .load_i(SET_EN), .load_val_i(hour_ld_s), .bcd_o(hour_s), .carry_o(hour_c_s)
    );
    bcd_field_cntr #(.MIN(DAY_MIN)) u_day (
        .clk_i(CLK1K), .rstn_i(RSTN), .max_i(day_max_s), .en_i(hour_c_s),
        .load_i(SET_EN), .load_val_i(day_ld_s), .bcd_o(day_s), .carry_o(day_c_s)
    );
    bcd_field_cntr #(.MIN(MON_MIN)) u_mon (
        .clk_i(CLK1K), .rstn_i(RSTN), .max_i(MON_MAX), .en_i(day_c_s),
        .load_i(SET_EN), .load_val_i(mon_ld_s), .bcd_o(mon_s), .carry_o()
    );

    // Alarm looks at the time the fields are about to take; sec_c_s already
    // implies a tick that lands on SEC=00, so it fires at most once a minute.
    always_comb begin
        min_nxt_s  = min_s;
        hour_nxt_s = hour_s;
        alarm_d    = 1'b0;
        if (min_c_s) begin
            min_nxt_s = MIN_MIN;
        end else begin
            min_nxt_s = bcd_inc(min_s);
        end
        if (hour_c_s) begin
            hour_nxt_s = HOUR_MIN;
        end else if (min_c_s) begin
            hour_nxt_s = bcd_inc(hour_s);
        end else begin
            hour_nxt_s = hour_s;
        end
        if (ALM_EN && sec_c_s && (min_nxt_s == ALM_MIN) && (hour_nxt_s == ALM_HOUR)) begin
            alarm_d = 1'b1;
        end else begin
            alarm_d = 1'b0;
        end
    end

    // Prescaler and pulse registers.
    always_ff @(posedge CLK1K) begin
        if (!RSTN) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            alarm_q <= alarm_d;
        end
    end

    assign h12_s = to_12h(hour_s);

    assign SEC   = sec_s;
    assign MIN   = min_s;
    assign HOUR  = MODE12 ? h12_s[7:0] : hour_s;
    assign DAY   = day_s;
    assign MON   = mon_s;
    assign PM    = h12_s[8];
    assign TICK  = tick_q;
    assign ALARM = alarm_q;

endmodule
